tea_host_ctrl: RTL and testbench

- Hardware host for the TEA cipher core. Performs, in RTL, the role the bench plays today.
- Holds the 128-bit key in four word registers and serves key words to the core's oKey_address lookup.
- Accepts 64-bit cipher/decipher requests over a valid/ready handshake, drives the core's start inputs and waits for done.
- Returns the result over a valid/ready response channel, with a timeout guard.

---
 rtl/tea_pkg.sv | 18 +
 rtl/tea_host_ctrl_if.sv | 27 ++
 rtl/tea_key_store.sv | 48 ++++
 rtl/tea_host_ctrl.sv | 172 +++++++++++++++++
 tb/tb_tea_host_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tea_pkg.sv
// Shared constants, state and mode encodings for the TEA cipher host and core.
package tea_pkg;

    localparam int          WORD_SIZE    = 32;
    localparam logic [31:0] DELTA        = 32'h9e3779b9;
    localparam int          ROUND_NUMBER = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } host_state_e;

    localparam logic MODE_CIPHER   = 1'b0;
    localparam logic MODE_DECIPHER = 1'b1;

endpackage

// File: rtl/tea_host_ctrl_if.sv
// Request/response channels between a client and the TEA host controller.
interface tea_host_ctrl_if
    import tea_pkg::*;
#(
    parameter int WORD_SIZE = tea_pkg::WORD_SIZE
);
    logic                 iReqValid;
    logic                 oReqReady;
    logic                 iReqMode;
    logic [WORD_SIZE-1:0] iReqV0;
    logic [WORD_SIZE-1:0] iReqV1;
    logic                 oRspValid;
    logic                 iRspReady;
    logic [WORD_SIZE-1:0] oRspC0;
    logic [WORD_SIZE-1:0] oRspC1;
    logic                 oRspTimeout;

    modport master (
        output iReqValid, iReqMode, iReqV0, iReqV1, iRspReady,
        input  oReqReady, oRspValid, oRspC0, oRspC1, oRspTimeout
    );

    modport slave (
        input  iReqValid, iReqMode, iReqV0, iReqV1, iRspReady,
        output oReqReady, oRspValid, oRspC0, oRspC1, oRspTimeout
    );
endinterface

// File: rtl/tea_key_store.sv
// Four-word key register file with a written-word mask and a combinational
// read port serving the cipher core's key lookups.
module tea_key_store
    import tea_pkg::*;
#(
    parameter int WORD_SIZE = tea_pkg::WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_allow_i,
    input  logic                 wr_en_i,
    input  logic [1:0]           wr_addr_i,
    input  logic [WORD_SIZE-1:0] wr_data_i,
    input  logic [1:0]           rd_addr_i,
    output logic [WORD_SIZE-1:0] rd_data_o,
    output logic                 key_valid_o
);
    logic [3:0][WORD_SIZE-1:0] key_q, key_d;
    logic [3:0]                mask_q, mask_d;

    // Next-state for key words and mask; writes are dropped unless allowed.
    always_comb begin
        key_d  = key_q;
        mask_d = mask_q;
        if (wr_allow_i && wr_en_i) begin
            key_d[wr_addr_i]  = wr_data_i;
            mask_d[wr_addr_i] = 1'b1;
        end else begin
            key_d  = key_q;
            mask_d = mask_q;
        end
    end

    // Key and mask registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q  <= '0;
            mask_q <= 4'b0000;
        end else begin
            key_q  <= key_d;
            mask_q <= mask_d;
        end
    end

    assign rd_data_o   = key_q[rd_addr_i];
    assign key_valid_o = (mask_q == 4'b1111);

endmodule

// File: rtl/tea_host_ctrl.sv
// Host controller for the TEA core: accepts one block request at a time,
// drives the core's start level, captures the result or aborts on timeout.
module tea_host_ctrl
    import tea_pkg::*;
#(
    parameter int WORD_SIZE      = tea_pkg::WORD_SIZE,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iKeyWrEn,
    input  logic [1:0]           iKeyWrAddr,
    input  logic [WORD_SIZE-1:0] iKeyWrData,
    output logic                 oKeyValid,
    tea_host_ctrl_if.slave       bus,
    output logic                 oStartCipher,
    output logic                 oStartDecipher,
    output logic [WORD_SIZE-1:0] oV0,
    output logic [WORD_SIZE-1:0] oV1,
    input  logic [1:0]           iKey_address,
    output logic [WORD_SIZE-1:0] oKey_sub_i,
    input  logic [WORD_SIZE-1:0] iC0,
    input  logic [WORD_SIZE-1:0] iC1,
    input  logic                 iDone
);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    host_state_e          state_q, state_d;
    logic                 mode_q, mode_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_SIZE-1:0] v0_q, v0_d, v1_q, v1_d;
    logic [WORD_SIZE-1:0] c0_q, c0_d, c1_q, c1_d;
    logic                 to_q, to_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 start_c_q, start_c_d;
    logic                 start_dc_q, start_dc_d;
    logic                 key_valid_s;
    logic                 req_ready_s;
    logic                 accept_s;

    tea_key_store #(.WORD_SIZE(WORD_SIZE)) u_key_store (
        .clk         (clk),
        .rst         (rst),
        .wr_allow_i  (state_q == IDLE),
        .wr_en_i     (iKeyWrEn),
        .wr_addr_i   (iKeyWrAddr),
        .wr_data_i   (iKeyWrData),
        .rd_addr_i   (iKey_address),
        .rd_data_o   (oKey_sub_i),
        .key_valid_o (key_valid_s)
    );

    assign req_ready_s = (state_q == IDLE) && key_valid_s;
    assign accept_s    = bus.iReqValid && req_ready_s;

    // Next-state and register updates for the request/run/response sequence.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        v0_d        = v0_q;
        v1_d        = v1_q;
        c0_d        = c0_q;
        c1_d        = c1_q;
        to_d        = to_q;
        rsp_valid_d = rsp_valid_q;
        start_c_d   = start_c_q;
        start_dc_d  = start_dc_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    v0_d       = bus.iReqV0;
                    v1_d       = bus.iReqV1;
                    mode_d     = bus.iReqMode;
                    cnt_d      = '0;
                    start_c_d  = (bus.iReqMode == MODE_CIPHER);
                    start_dc_d = (bus.iReqMode == MODE_DECIPHER);
                    state_d    = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // A done sampled on the timeout cycle still counts as success.
                if (iDone) begin
                    c0_d        = iC0;
                    c1_d        = iC1;
                    to_d        = 1'b0;
                    start_c_d   = 1'b0;
                    start_dc_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q == TIMEOUT_LIM) begin
                    c0_d        = '0;
                    c1_d        = '0;
                    to_d        = 1'b1;
                    start_c_d   = 1'b0;
                    start_dc_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RESP: begin
                if (bus.iRspReady) begin
                    rsp_valid_d = 1'b0;
                    state_d     = DRAIN;
                end else begin
                    state_d = RESP;
                end
            end
            DRAIN: begin
                // Hold off new work until the core has released a stale done.
                if (!iDone) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d     = IDLE;
                start_c_d   = 1'b0;
                start_dc_d  = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Controller state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            v0_q        <= '0;
            v1_q        <= '0;
            c0_q        <= '0;
            c1_q        <= '0;
            to_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            start_c_q   <= 1'b0;
            start_dc_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            v0_q        <= v0_d;
            v1_q        <= v1_d;
            c0_q        <= c0_d;
            c1_q        <= c1_d;
            to_q        <= to_d;
            rsp_valid_q <= rsp_valid_d;
            start_c_q   <= start_c_d;
            start_dc_q  <= start_dc_d;
        end
    end

    assign oKeyValid       = key_valid_s;
    assign bus.oReqReady   = req_ready_s;
    assign bus.oRspValid   = rsp_valid_q;
    assign bus.oRspC0      = c0_q;
    assign bus.oRspC1      = c1_q;
    assign bus.oRspTimeout = to_q;
    assign oStartCipher    = start_c_q;
    assign oStartDecipher  = start_dc_q;
    assign oV0             = v0_q;
    assign oV1             = v1_q;

endmodule

// File: tb/tb_tea_host_ctrl.sv
// Self-checking bench for tea_host_ctrl with a behavioural TEA core model that
// fetches its key through the controller's key lookup port.
module tb_tea_host_ctrl;
    import tea_pkg::*;

    localparam int TMO      = 20;
    localparam int CORE_LAT = 6;

    logic        clk;
    logic        rst;
    logic        key_wr_en;
    logic [1:0]  key_wr_addr;
    logic [31:0] key_wr_data;
    logic        key_valid;
    logic        start_c, start_d;
    logic [31:0] ov0, ov1;
    logic [1:0]  key_addr, tb_addr, core_addr;
    logic [31:0] key_sub;
    logic [31:0] core_c0, core_c1;
    logic        core_done;

    tea_host_ctrl_if #(.WORD_SIZE(32)) bus ();

    tea_host_ctrl #(.WORD_SIZE(32), .TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .iKeyWrEn(key_wr_en), .iKeyWrAddr(key_wr_addr), .iKeyWrData(key_wr_data),
        .oKeyValid(key_valid), .bus(bus),
        .oStartCipher(start_c), .oStartDecipher(start_d), .oV0(ov0), .oV1(ov1),
        .iKey_address(key_addr), .oKey_sub_i(key_sub),
        .iC0(core_c0), .iC1(core_c1), .iDone(core_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign key_addr = (start_c | start_d) ? core_addr : tb_addr;

    function automatic logic [63:0] tea_enc(input logic [31:0] a, b, k0, k1, k2, k3);
        logic [31:0] y, z, s;
        y = a; z = b; s = 32'd0;
        for (int r = 0; r < ROUND_NUMBER; r++) begin
            s = s + DELTA;
            y = y + ((((z << 4) + k0) ^ (z + s)) ^ ((z >> 5) + k1));
            z = z + ((((y << 4) + k2) ^ (y + s)) ^ ((y >> 5) + k3));
        end
        return {y, z};
    endfunction

    function automatic logic [63:0] tea_dec(input logic [31:0] a, b, k0, k1, k2, k3);
        logic [31:0] y, z, s;
        y = a; z = b; s = 32'(DELTA * 32'(ROUND_NUMBER));
        for (int r = 0; r < ROUND_NUMBER; r++) begin
            z = z - ((((y << 4) + k2) ^ (y + s)) ^ ((y >> 5) + k3));
            y = y - ((((z << 4) + k0) ^ (z + s)) ^ ((z >> 5) + k1));
            s = s - DELTA;
        end
        return {y, z};
    endfunction

    // Core model: reads key words 0..3 over the first four start cycles,
    // raises done CORE_LAT edges later, keeps it while start is high, then
    // holds it for done_hold extra cycles after start drops.
    logic [31:0] kf [4];
    int          core_cnt, hold_cnt, done_hold;
    bit          never_done;
    int          dec_cycles, cip_cycles;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_cnt  <= 0;
            core_addr <= 2'd0;
            core_done <= 1'b0;
            core_c0   <= 32'd0;
            core_c1   <= 32'd0;
            hold_cnt  <= 0;
        end else if (start_c || start_d) begin
            if (core_cnt < 4) kf[core_cnt] <= key_sub;
            core_addr <= core_addr + 2'd1;
            core_cnt  <= core_cnt + 1;
            hold_cnt  <= done_hold;
            if (core_cnt == CORE_LAT && !never_done) begin
                core_done <= 1'b1;
                if (start_d) {core_c0, core_c1} <= tea_dec(ov0, ov1, kf[0], kf[1], kf[2], kf[3]);
                else         {core_c0, core_c1} <= tea_enc(ov0, ov1, kf[0], kf[1], kf[2], kf[3]);
            end
        end else begin
            core_cnt  <= 0;
            core_addr <= 2'd0;
            if (core_done) begin
                if (hold_cnt == 0) core_done <= 1'b0;
                else               hold_cnt  <= hold_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (start_d) dec_cycles <= dec_cycles + 1;
        if (start_c) cip_cycles <= cip_cycles + 1;
    end

    int n_pass, n_total;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic write_key(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        key_wr_en = 1'b1; key_wr_addr = a; key_wr_data = d;
        @(posedge clk); #1;
        key_wr_en = 1'b0;
    endtask

    task automatic send_req(input logic mode, input logic [31:0] v0, v1, output bit ok);
        int w;
        @(negedge clk);
        bus.iReqValid = 1'b1; bus.iReqMode = mode; bus.iReqV0 = v0; bus.iReqV1 = v1;
        w = 0;
        while (!bus.oReqReady && w < 50) begin @(negedge clk); w++; end
        ok = bus.oReqReady;
        if (!ok) begin
            bus.iReqValid = 1'b0;
            chk("req_accept", 64'(ok), 64'd1);
            return;
        end
        @(posedge clk); #1;
        bus.iReqValid = 1'b0;
        bus.iReqMode  = ~mode;  // must not affect the request in flight
    endtask

    // Edges after the acceptance edge until oRspValid is seen.
    task automatic wait_rsp(output logic [31:0] c0, c1, output logic to, output int edges);
        edges = 0;
        do begin
            @(posedge clk); edges++;
            @(negedge clk);
        end while (!bus.oRspValid && edges < 200);
        c0 = bus.oRspC0; c1 = bus.oRspC1; to = bus.oRspTimeout;
    endtask

    task automatic ack_rsp();
        @(negedge clk);
        bus.iRspReady = 1'b1;
        @(posedge clk); #1;
        bus.iRspReady = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] exp;
    } key_vec_t;

    typedef struct {
        logic        mode;
        logic [31:0] v0, v1, e0, e1;
    } req_vec_t;

    logic [31:0] K [4];
    key_vec_t    kv [4];
    req_vec_t    rv [4];

    initial begin
        logic [63:0] x, y;
        logic [31:0] c0, c1, s0, s1;
        logic        to;
        int          edges, cnt_a, cnt_b, bad, high_cycles, w;
        bit          ok, stable;

        K[0] = 32'h132acf42; K[1] = 32'h234acb45; K[2] = 32'h3235acbe; K[3] = 32'h4533f235;
        for (int i = 0; i < 4; i++) kv[i] = '{addr: 2'(i), exp: K[i]};
        x = tea_enc(32'h3d45f7a7, 32'h235fcb21, K[0], K[1], K[2], K[3]);
        rv[0] = '{1'b0, 32'h3d45f7a7, 32'h235fcb21, x[63:32], x[31:0]};
        rv[1] = '{1'b1, x[63:32], x[31:0], 32'h3d45f7a7, 32'h235fcb21};
        y = tea_dec(32'h01234567, 32'h89abcdef, K[0], K[1], K[2], K[3]);
        rv[2] = '{1'b1, 32'h01234567, 32'h89abcdef, y[63:32], y[31:0]};
        y = tea_enc(32'h0, 32'h0, K[0], K[1], K[2], K[3]);
        rv[3] = '{1'b0, 32'h0, 32'h0, y[63:32], y[31:0]};

        n_pass = 0; n_total = 0;
        dec_cycles = 0; cip_cycles = 0;
        never_done = 1'b0; done_hold = 0;
        key_wr_en = 1'b0; key_wr_addr = 2'd0; key_wr_data = 32'd0; tb_addr = 2'd0;
        bus.iReqValid = 1'b0; bus.iReqMode = 1'b0; bus.iReqV0 = 32'd0; bus.iReqV1 = 32'd0;
        bus.iRspReady = 1'b0;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 64'({key_valid, bus.oReqReady, bus.oRspValid, bus.oRspTimeout, start_c, start_d}), 64'd0);
        chk("reset_data", {ov0 | ov1, bus.oRspC0 | bus.oRspC1}, 64'd0);
        rst = 1'b1;

        // No keys loaded: requests are refused.
        @(negedge clk);
        bus.iReqValid = 1'b1;
        bad = 0;
        repeat (5) begin @(negedge clk); if (bus.oReqReady || start_c || start_d) bad++; end
        bus.iReqValid = 1'b0;
        chk("nokey_refuse", 64'(bad), 64'd0);

        for (int i = 0; i < 3; i++) write_key(2'(i), K[i]);
        @(negedge clk);
        chk("keyvalid_3of4", 64'(key_valid), 64'd0);
        write_key(2'd3, K[3]);
        @(negedge clk);
        chk("keyvalid_4of4", 64'(key_valid), 64'd1);
        chk("ready_idle", 64'(bus.oReqReady), 64'd1);

        for (int i = 0; i < 4; i++) begin
            tb_addr = kv[i].addr; #1;
            chk($sformatf("key_read%0d", i), 64'(key_sub), 64'(kv[i].exp));
        end

        // Request table: round trip, independent decipher, all-zero block.
        for (int i = 0; i < 4; i++) begin
            cnt_a = dec_cycles; cnt_b = cip_cycles;
            send_req(rv[i].mode, rv[i].v0, rv[i].v1, ok);
            wait_rsp(c0, c1, to, edges);
            chk($sformatf("req%0d_data", i), {c0, c1}, {rv[i].e0, rv[i].e1});
            chk($sformatf("req%0d_timeout", i), 64'(to), 64'd0);
            chk($sformatf("req%0d_latency", i), 64'(edges), 64'(CORE_LAT + 2));
            if (rv[i].mode == MODE_CIPHER)
                chk($sformatf("req%0d_wrong_start", i), 64'(dec_cycles - cnt_a), 64'd0);
            else
                chk($sformatf("req%0d_wrong_start", i), 64'(cip_cycles - cnt_b), 64'd0);
            ack_rsp();
            @(negedge clk);
            chk($sformatf("req%0d_drain_busy", i), 64'(bus.oReqReady), 64'd0);
            @(negedge clk);
            chk($sformatf("req%0d_drain_1cyc", i), 64'(bus.oReqReady), 64'd1);
        end

        // Backpressure: response held for 10 cycles stays stable.
        send_req(rv[0].mode, rv[0].v0, rv[0].v1, ok);
        wait_rsp(c0, c1, to, edges);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!bus.oRspValid || bus.oReqReady || bus.oRspC0 !== c0 || bus.oRspC1 !== c1 ||
                bus.oRspTimeout !== to || start_c || start_d) stable = 1'b0;
        end
        chk("bp_stable", 64'(stable), 64'd1);
        chk("bp_data", {bus.oRspC0, bus.oRspC1}, {rv[0].e0, rv[0].e1});
        ack_rsp();
        repeat (2) @(negedge clk);

        // Drain: done lingers after start drops; controller waits for it.
        done_hold = 8;
        send_req(rv[1].mode, rv[1].v0, rv[1].v1, ok);
        wait_rsp(c0, c1, to, edges);
        ack_rsp();
        bad = 0; high_cycles = 0;
        @(negedge clk);
        while (core_done && high_cycles < 40) begin
            high_cycles++;
            if (bus.oReqReady) bad++;
            @(negedge clk);
        end
        chk("drain_done_seen", 64'(high_cycles > 0), 64'd1);
        chk("drain_ready_low", 64'(bad), 64'd0);
        chk("drain_last_cycle", 64'(bus.oReqReady), 64'd0);
        @(negedge clk);
        chk("drain_release", 64'(bus.oReqReady), 64'd1);
        done_hold = 0;

        // Timeout: core never answers.
        never_done = 1'b1;
        send_req(MODE_CIPHER, 32'h11111111, 32'h22222222, ok);
        wait_rsp(c0, c1, to, edges);
        // Counter hits TMO on the 21st edge: the 22nd cycle counting acceptance as cycle 0.
        chk("tmo_latency", 64'(edges), 64'(TMO + 1));
        chk("tmo_flag", 64'(to), 64'd1);
        chk("tmo_data", {c0, c1}, 64'd0);
        chk("tmo_starts", 64'({start_c, start_d}), 64'd0);
        ack_rsp();

        // Key write while busy is ignored.
        send_req(MODE_CIPHER, 32'h5, 32'h6, ok);
        write_key(2'd0, 32'hffffffff);
        wait_rsp(c0, c1, to, edges);
        ack_rsp();
        w = 0;
        while (!bus.oReqReady && w < 10) begin @(negedge clk); w++; end
        tb_addr = 2'd0; #1;
        chk("busy_write_key0", 64'(key_sub), 64'(K[0]));
        chk("busy_write_valid", 64'(key_valid), 64'd1);

        // Asynchronous reset mid-RUN.
        send_req(MODE_DECIPHER, 32'h7, 32'h8, ok);
        @(posedge clk); #2;
        chk("run_before_rst", 64'({start_c, start_d}), 64'b01);
        rst = 1'b0; #1;
        chk("async_rst", 64'({start_c, start_d, bus.oRspValid, key_valid, bus.oReqReady}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        never_done = 1'b0;
        for (int i = 0; i < 3; i++) write_key(2'(i), K[i]);
        @(negedge clk);
        bus.iReqValid = 1'b1;
        bad = 0;
        repeat (3) begin @(negedge clk); if (bus.oReqReady || start_c || start_d) bad++; end
        bus.iReqValid = 1'b0;
        chk("rst_refuse_3keys", 64'(bad), 64'd0);
        write_key(2'd3, K[3]);
        @(negedge clk);
        chk("rst_reload_ready", 64'(bus.oReqReady), 64'd1);
        send_req(rv[0].mode, rv[0].v0, rv[0].v1, ok);
        wait_rsp(c0, c1, to, edges);
        chk("rst_reload_data", {c0, c1}, {rv[0].e0, rv[0].e1});
        ack_rsp();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
